// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared constants, types and helpers for the floating-point
//                register file and FPU writeback.
//                FLEN_DEFAULT - default FP data width (32 or 64)
//                NUM_FPREGS   - default architectural FP register count
//                nan_box()    - widens a single-precision value to 64 bits
//                               by filling the upper half with ones
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int FLEN_DEFAULT = 32;
    localparam int NUM_FPREGS   = 32;

    typedef logic [FLEN_DEFAULT-1:0]        fp_word_t;
    typedef logic [$clog2(NUM_FPREGS)-1:0]  fp_addr_t;

    // A single-precision value held in a 64-bit register must look like a
    // NaN to double-precision ops, so the upper word is all ones.
    function automatic logic [63:0] nan_box(input logic [31:0] sp_val);
        return {32'hFFFF_FFFF, sp_val};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_regfile_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_regfile_sb_if
//  Description : Bus bundle between issue/writeback logic (master) and the
//                FP register file with scoreboard (slave).
//                Read      : raddr_i -> rdata_o, rbusy_o
//                Issue     : issue_valid_i, issue_rd_i
//                Writeback : wvalid_i, waddr_i, wdata_i, wsingle_i
//                Store     : store_req_i, store_addr_i -> store_valid_o,
//                            store_data_o
//                FS state  : dirty_o, dirty_clr_i
//                Direction suffixes are from the register file's viewpoint.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fp_regfile_sb_if import fp_pkg::*; #(
    parameter int FLEN         = FLEN_DEFAULT,
    parameter int NUM_REGS     = NUM_FPREGS,
    parameter int NUM_RD_PORTS = 3,
    parameter int AW           = $clog2(NUM_REGS)
);
    logic [NUM_RD_PORTS-1:0][AW-1:0]   raddr_i;
    logic [NUM_RD_PORTS-1:0][FLEN-1:0] rdata_o;
    logic [NUM_RD_PORTS-1:0]           rbusy_o;
    logic                              issue_valid_i;
    logic [AW-1:0]                     issue_rd_i;
    logic                              wvalid_i;
    logic [AW-1:0]                     waddr_i;
    logic [FLEN-1:0]                   wdata_i;
    logic                              wsingle_i;
    logic                              store_req_i;
    logic [AW-1:0]                     store_addr_i;
    logic                              store_valid_o;
    logic [FLEN-1:0]                   store_data_o;
    logic                              dirty_o;
    logic                              dirty_clr_i;

    modport master (
        output raddr_i, issue_valid_i, issue_rd_i, wvalid_i, waddr_i, wdata_i,
               wsingle_i, store_req_i, store_addr_i, dirty_clr_i,
        input  rdata_o, rbusy_o, store_valid_o, store_data_o, dirty_o
    );

    modport slave (
        input  raddr_i, issue_valid_i, issue_rd_i, wvalid_i, waddr_i, wdata_i,
               wsingle_i, store_req_i, store_addr_i, dirty_clr_i,
        output rdata_o, rbusy_o, store_valid_o, store_data_o, dirty_o
    );

endinterface
`default_nettype wire

// File: rtl/fp_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : fp_scoreboard
//  Description : One busy bit per FP register. Issue of a long-latency op
//                sets the destination bit, writeback clears it; a same-cycle
//                issue and writeback to one register leaves it set.
//                Ports: clk_i, rst_ni, issue_valid_i/issue_rd_i,
//                wvalid_i/waddr_i, raddr_i -> rbusy_o.
//                FP_REGFILE_BYPASS_EN: a register being written this cycle
//                reads as not busy unless it is also being re-issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_scoreboard import fp_pkg::*; #(
    parameter int NUM_REGS     = NUM_FPREGS,
    parameter int NUM_RD_PORTS = 3,
    parameter int AW           = $clog2(NUM_REGS)
) (
    input  wire logic                            clk_i,
    input  wire logic                            rst_ni,
    input  wire logic                            issue_valid_i,
    input  wire logic [AW-1:0]                   issue_rd_i,
    input  wire logic                            wvalid_i,
    input  wire logic [AW-1:0]                   waddr_i,
    input  wire logic [NUM_RD_PORTS-1:0][AW-1:0] raddr_i,
    output      logic [NUM_RD_PORTS-1:0]         rbusy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Clear first, then set, so a new issue overrides the retiring write.
    always_comb begin
        busy_d = busy_q;
        if (wvalid_i) begin
            busy_d[waddr_i] = 1'b0;
        end
        if (issue_valid_i) begin
            busy_d[issue_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rbusy_o[p] = busy_q[raddr_i[p]];
`ifdef FP_REGFILE_BYPASS_EN
            if (wvalid_i && (raddr_i[p] == waddr_i)) begin
                rbusy_o[p] = issue_valid_i && (issue_rd_i == raddr_i[p]);
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : fp_regfile_sb
//  Description : Floating-point register file with integrated scoreboard.
//                NUM_RD_PORTS combinational read ports with busy lookup, one
//                writeback port (NaN-boxing single-precision data when
//                FLEN=64), a latency-1 registered store-data port and the
//                FS dirty flag.
//                Ports: clk_i, rst_ni (async, active low),
//                       bus (fp_regfile_sb_if.slave) carrying read, issue,
//                       writeback, store and dirty signals.
//                FP_REGFILE_BYPASS_EN: forward writeback data to the read
//                ports and the store port in the write cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_regfile_sb import fp_pkg::*; #(
    parameter int FLEN         = FLEN_DEFAULT,
    parameter int NUM_REGS     = NUM_FPREGS,
    parameter int NUM_RD_PORTS = 3,
    parameter int AW           = $clog2(NUM_REGS)
) (
    input wire logic       clk_i,
    input wire logic       rst_ni,
    fp_regfile_sb_if.slave bus
);

    logic [NUM_REGS-1:0][FLEN-1:0]     regs_q;
    logic [FLEN-1:0]                   w_wdata_eff;
    logic [NUM_RD_PORTS-1:0][FLEN-1:0] w_rdata;
    logic [FLEN-1:0]                   store_data_d;
    logic [FLEN-1:0]                   store_data_q;
    logic                              store_valid_q;
    logic                              dirty_d;
    logic                              dirty_q;

    generate
        if (FLEN == 64) begin : g_nanbox
            logic [63:0] w_boxed;
            assign w_boxed     = nan_box(bus.wdata_i[31:0]);
            assign w_wdata_eff = bus.wsingle_i ? w_boxed[FLEN-1:0] : bus.wdata_i;
        end else begin : g_no_nanbox
            assign w_wdata_eff = bus.wdata_i;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q <= '0;
        end else if (bus.wvalid_i) begin
            regs_q[bus.waddr_i] <= w_wdata_eff;
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            w_rdata[p] = regs_q[bus.raddr_i[p]];
`ifdef FP_REGFILE_BYPASS_EN
            if (bus.wvalid_i && (bus.raddr_i[p] == bus.waddr_i)) begin
                w_rdata[p] = w_wdata_eff;
            end
`endif
        end
    end

    assign bus.rdata_o = w_rdata;

    fp_scoreboard #(
        .NUM_REGS     (NUM_REGS),
        .NUM_RD_PORTS (NUM_RD_PORTS),
        .AW           (AW)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .issue_valid_i (bus.issue_valid_i),
        .issue_rd_i    (bus.issue_rd_i),
        .wvalid_i      (bus.wvalid_i),
        .waddr_i       (bus.waddr_i),
        .raddr_i       (bus.raddr_i),
        .rbusy_o       (bus.rbusy_o)
    );

    // Store data only updates on a request so it holds between pulses.
    always_comb begin
        store_data_d = store_data_q;
        if (bus.store_req_i) begin
            store_data_d = regs_q[bus.store_addr_i];
`ifdef FP_REGFILE_BYPASS_EN
            if (bus.wvalid_i && (bus.store_addr_i == bus.waddr_i)) begin
                store_data_d = w_wdata_eff;
            end
`endif
        end
    end

    // A write in the same cycle as a clear leaves the state dirty.
    always_comb begin
        dirty_d = dirty_q;
        if (bus.dirty_clr_i) begin
            dirty_d = 1'b0;
        end
        if (bus.wvalid_i) begin
            dirty_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            store_valid_q <= 1'b0;
            store_data_q  <= '0;
            dirty_q       <= 1'b0;
        end else begin
            store_valid_q <= bus.store_req_i;
            store_data_q  <= store_data_d;
            dirty_q       <= dirty_d;
        end
    end

    assign bus.store_valid_o = store_valid_q;
    assign bus.store_data_o  = store_data_q;
    assign bus.dirty_o       = dirty_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_regfile_sb
//  Description : Self-checking bench for fp_regfile_sb configured with
//                FLEN=64, NUM_REGS=16, NUM_RD_PORTS=4. Stimulus pushes
//                expected values into queues; a monitor on the falling edge
//                pops and compares combinational outputs and store pulses.
//                Expectations follow FP_REGFILE_BYPASS_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_regfile_sb;

    localparam int FLEN = 64;
    localparam int NR   = 16;
    localparam int NRP  = 4;
    localparam int AW   = 4;

`ifdef FP_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int K_RDATA  = 0;
    localparam int K_RBUSY  = 1;
    localparam int K_DIRTY  = 2;
    localparam int K_SVALID = 3;
    localparam int K_SDATA  = 4;

    typedef struct {
        string       name;
        int          kind;
        int          port;
        logic [63:0] exp;
    } chk_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    chk_t        q_comb[$];
    logic [63:0] q_st[$];
    int          checks = 0;
    int          errors = 0;

    fp_regfile_sb_if #(.FLEN(FLEN), .NUM_REGS(NR), .NUM_RD_PORTS(NRP)) bus ();

    fp_regfile_sb #(
        .FLEN         (FLEN),
        .NUM_REGS     (NR),
        .NUM_RD_PORTS (NRP)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Monitor: combinational checks queued this cycle, plus store pulses.
    always @(negedge clk) begin
        logic [63:0] act;
        chk_t        c;
        logic [63:0] e;
        while (q_comb.size() > 0) begin
            c = q_comb.pop_front();
            case (c.kind)
                K_RDATA:  act = bus.rdata_o[c.port];
                K_RBUSY:  act = {63'b0, bus.rbusy_o[c.port]};
                K_DIRTY:  act = {63'b0, bus.dirty_o};
                K_SVALID: act = {63'b0, bus.store_valid_o};
                default:  act = bus.store_data_o;
            endcase
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s: actual %h required %h", c.name, act, c.exp);
            end
        end
        if (bus.store_valid_o === 1'b1) begin
            checks++;
            if (q_st.size() == 0) begin
                errors++;
                $display("FAIL store_unexpected: actual pulse data %h required no pulse", bus.store_data_o);
            end else begin
                e = q_st.pop_front();
                if (bus.store_data_o !== e) begin
                    errors++;
                    $display("FAIL store_data: actual %h required %h", bus.store_data_o, e);
                end
            end
        end
    end

    task automatic expect_c(input string n, input int k, input int p, input logic [63:0] v);
        chk_t c;
        c.name = n;
        c.kind = k;
        c.port = p;
        c.exp  = v;
        q_comb.push_back(c);
    endtask

    task automatic idle();
        bus.issue_valid_i = 1'b0;
        bus.issue_rd_i    = '0;
        bus.wvalid_i      = 1'b0;
        bus.waddr_i       = '0;
        bus.wdata_i       = '0;
        bus.wsingle_i     = 1'b0;
        bus.store_req_i   = 1'b0;
        bus.store_addr_i  = '0;
        bus.dirty_clr_i   = 1'b0;
    endtask

    // Advance to just after the next rising edge and default the strobes.
    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr(input int a, input logic [63:0] d, input logic s);
        bus.wvalid_i  = 1'b1;
        bus.waddr_i   = AW'(a);
        bus.wdata_i   = d;
        bus.wsingle_i = s;
    endtask

    function automatic logic [63:0] pat(input int i);
        return {32'hC0DE_0000 | 32'(i), 32'h0F0F_0000 | 32'(i * 17)};
    endfunction

    initial begin
        bus.raddr_i = '0;
        idle();
        next();
        next();
        rst_n = 1'b1;
        next();

        // Build non-zero state, then reset asynchronously mid-cycle.
        wr(1, 64'h1111, 1'b0);
        bus.issue_valid_i = 1'b1;
        bus.issue_rd_i    = AW'(2);
        next();
        bus.raddr_i[0] = AW'(1);
        bus.raddr_i[1] = AW'(2);
        expect_c("pre_rst_rdata", K_RDATA, 0, 64'h1111);
        expect_c("pre_rst_busy",  K_RBUSY, 1, 64'd1);
        expect_c("pre_rst_dirty", K_DIRTY, 0, 64'd1);
        bus.store_req_i  = 1'b1;
        bus.store_addr_i = AW'(1);
        next();
        rst_n = 1'b0;
        expect_c("rst_rdata0", K_RDATA,  0, 64'd0);
        expect_c("rst_rdata1", K_RDATA,  1, 64'd0);
        expect_c("rst_busy",   K_RBUSY,  1, 64'd0);
        expect_c("rst_dirty",  K_DIRTY,  0, 64'd0);
        expect_c("rst_svalid", K_SVALID, 0, 64'd0);
        expect_c("rst_sdata",  K_SDATA,  0, 64'd0);
        next();
        rst_n = 1'b1;

        // NaN-boxing of a single-precision write.
        wr(5, 64'h12345678_3F800000, 1'b1);
        bus.raddr_i[1] = AW'(5);
        expect_c("nanbox_wcycle", K_RDATA, 1, BYP ? 64'hFFFFFFFF_3F800000 : 64'd0);
        expect_c("dirty_wcycle",  K_DIRTY, 0, 64'd0);
        next();
        bus.raddr_i[0] = AW'(5);
        expect_c("nanbox_read", K_RDATA, 0, 64'hFFFFFFFF_3F800000);
        expect_c("dirty_set",   K_DIRTY, 0, 64'd1);
        next();
        wr(5, 64'h40000000_00000000, 1'b0);
        next();
        expect_c("double_read", K_RDATA, 0, 64'h40000000_00000000);
        next();

        // Scoreboard on f7.
        bus.issue_valid_i = 1'b1;
        bus.issue_rd_i    = AW'(7);
        bus.raddr_i[2]    = AW'(7);
        expect_c("busy_issue_cycle", K_RBUSY, 2, 64'd0);
        next();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                bus.issue_valid_i = 1'b1;
                bus.issue_rd_i    = AW'(7);
            end
            expect_c($sformatf("busy_hold%0d", i), K_RBUSY, 2, 64'd1);
            next();
        end
        wr(7, 64'h7, 1'b0);
        expect_c("busy_wb_cycle", K_RBUSY, 2, BYP ? 64'd0 : 64'd1);
        next();
        expect_c("busy_cleared", K_RBUSY, 2, 64'd0);
        wr(7, 64'h77, 1'b0);
        bus.issue_valid_i = 1'b1;
        bus.issue_rd_i    = AW'(7);
        expect_c("busy_iss_wb_cycle", K_RBUSY, 2, BYP ? 64'd1 : 64'd0);
        next();
        expect_c("busy_set_wins", K_RBUSY, 2, 64'd1);
        wr(8, 64'h8, 1'b0);
        bus.raddr_i[3] = AW'(8);
        expect_c("busy_nonbusy_wcycle", K_RBUSY, 3, 64'd0);
        next();
        expect_c("busy_nonbusy_after", K_RBUSY, 3, 64'd0);
        expect_c("busy_still_set",     K_RBUSY, 2, 64'd1);
        wr(7, 64'h777, 1'b0);
        next();
        expect_c("busy_final_clear", K_RBUSY, 2, 64'd0);
        next();

        // Store port.
        wr(3, 64'h00000000_DEADBEEF, 1'b0);
        next();
        bus.store_req_i  = 1'b1;
        bus.store_addr_i = AW'(3);
        q_st.push_back(64'h00000000_DEADBEEF);
        next();
        bus.store_req_i  = 1'b1;
        bus.store_addr_i = AW'(3);
        q_st.push_back(64'h00000000_DEADBEEF);
        expect_c("store_valid_hi", K_SVALID, 0, 64'd1);
        next();
        bus.store_req_i  = 1'b1;
        bus.store_addr_i = AW'(3);
        wr(3, 64'h1234, 1'b0);
        q_st.push_back(BYP ? 64'h1234 : 64'h00000000_DEADBEEF);
        next();
        next();
        expect_c("store_valid_lo", K_SVALID, 0, 64'd0);
        expect_c("store_data_hold", K_SDATA, 0, BYP ? 64'h1234 : 64'h00000000_DEADBEEF);
        next();

        // Dirty flag.
        bus.dirty_clr_i = 1'b1;
        next();
        expect_c("dirty_cleared", K_DIRTY, 0, 64'd0);
        next();
        wr(9, 64'h9, 1'b0);
        bus.dirty_clr_i = 1'b1;
        expect_c("dirty_wr_clr_cycle", K_DIRTY, 0, 64'd0);
        next();
        expect_c("dirty_set_wins", K_DIRTY, 0, 64'd1);
        next();

        // Fill all registers, read every one across the four ports.
        for (int i = 0; i < NR; i++) begin
            wr(i, pat(i), 1'b0);
            next();
        end
        for (int g = 0; g < 4; g++) begin
            for (int p = 0; p < NRP; p++) begin
                bus.raddr_i[p] = AW'(p * 4 + g);
                expect_c($sformatf("fill_r%0d_p%0d", p * 4 + g, p), K_RDATA, p, pat(p * 4 + g));
            end
            next();
        end

        next();
        next();
        checks++;
        if (q_st.size() != 0) begin
            errors++;
            $display("FAIL store_pulses_missing: actual %0d outstanding required 0", q_st.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL watchdog: actual timeout required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
